// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared definitions for the RSA codec and its benches:
//                transaction mode encoding, codec FSM state encoding and the
//                default test-key constants (modulus, public and private
//                exponents) shared with the rsa_decoder benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    // Transaction mode, sampled together with each operand
    localparam logic MODE_ENC = 1'b0;   // use public exponent e
    localparam logic MODE_DEC = 1'b1;   // use private exponent d

    // Default test key: N = 53 * 67, e * d = 1 mod phi(N)
    localparam int TEST_N = 3551;
    localparam int TEST_E = 5;
    localparam int TEST_D = 1373;

    // Codec FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/mod_exp.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp
//  Description : Montgomery modular exponentiator, z = a^e mod N.
//                A single word-serial Montgomery multiplier (radix 2^LOGR)
//                is sequenced through: conversion into the Montgomery
//                domain, left-to-right square-and-multiply over all N_BIT
//                exponent bits, and conversion back out.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                start  - one-cycle pulse, samples a and e
//                a, e   - base (< N) and exponent
//                z      - result, held until the next run completes
//                done   - one-cycle pulse when z is updated
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_exp #(
    parameter int N      = 3551,
    parameter int N_BIT  = 12,
    parameter int LOGR   = 3,
    parameter int P      = 1,
    parameter int RMODN  = 545,
    parameter int R2MODN = 2292
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] e,
    output logic [N_BIT-1:0] z,
    output logic             done
);

    // Number of radix-2^LOGR digits in an operand
    localparam int K  = (N_BIT + LOGR - 1) / LOGR;
    // Accumulator width: holds T + digit*y + q*N < 16N comfortably
    localparam int TW = N_BIT + LOGR + 2;
    localparam int CW = $clog2(K + 1);
    localparam int IW = (N_BIT > 1) ? $clog2(N_BIT) : 1;

    localparam logic [N_BIT-1:0] C_N    = N_BIT'(N);
    localparam logic [TW-1:0]    C_NW   = TW'(N);
    localparam logic [LOGR-1:0]  C_P    = LOGR'(P);
    localparam logic [N_BIT-1:0] C_R1   = N_BIT'(RMODN);
    localparam logic [N_BIT-1:0] C_R2   = N_BIT'(R2MODN);
    localparam logic [N_BIT-1:0] C_ONE  = N_BIT'(1);
    localparam logic [CW-1:0]    C_K    = CW'(K);
    localparam logic [IW-1:0]    C_TOP  = IW'(N_BIT - 1);

    localparam logic [2:0] MS_IDLE = 3'd0;
    localparam logic [2:0] MS_TOM  = 3'd1;   // a -> a*R mod N
    localparam logic [2:0] MS_SQR  = 3'd2;   // acc = acc^2
    localparam logic [2:0] MS_MUL  = 3'd3;   // acc = acc * aR
    localparam logic [2:0] MS_FROM = 3'd4;   // acc -> acc*R^-1 mod N

    logic [2:0]       st_q,   st_d;
    logic [N_BIT-1:0] x_q,    x_d;     // multiplier operand, consumed a digit per cycle
    logic [N_BIT-1:0] y_q,    y_d;     // multiplicand
    logic [TW-1:0]    t_q,    t_d;     // Montgomery accumulator
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [N_BIT-1:0] am_q,   am_d;    // base in Montgomery form
    logic [N_BIT-1:0] exp_q,  exp_d;
    logic [IW-1:0]    idx_q,  idx_d;   // current exponent bit
    logic [N_BIT-1:0] z_q,    z_d;
    logic             done_q, done_d;

    logic [TW-1:0]    w_dig;
    logic [TW-1:0]    w_y;
    logic [TW-1:0]    w_t1;
    logic [LOGR-1:0]  w_qd;
    logic [TW-1:0]    w_t2;
    logic [N_BIT-1:0] w_res;

    // One Montgomery digit step: T = (T + x_i*y + q*N) / 2^LOGR,
    // with q chosen so the low LOGR bits of the sum vanish.
    always_comb begin
        w_dig = {{(TW-LOGR){1'b0}}, x_q[LOGR-1:0]};
        w_y   = {{(TW-N_BIT){1'b0}}, y_q};
        w_t1  = t_q + w_dig * w_y;
        w_qd  = w_t1[LOGR-1:0] * C_P;
        w_t2  = w_t1 + {{(TW-LOGR){1'b0}}, w_qd} * C_NW;
        // After K steps T < 2N; one conditional subtract finishes reduction
        w_res = (t_q >= C_NW) ? (t_q[N_BIT-1:0] - C_N) : t_q[N_BIT-1:0];
    end

    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        y_d    = y_q;
        t_d    = t_q;
        cnt_d  = cnt_q;
        am_d   = am_q;
        exp_d  = exp_q;
        idx_d  = idx_q;
        z_d    = z_q;
        done_d = 1'b0;
        if (st_q == MS_IDLE) begin
            if (start) begin
                exp_d = e;
                x_d   = a;
                y_d   = C_R2;
                t_d   = '0;
                cnt_d = '0;
                st_d  = MS_TOM;
            end
        end else if (cnt_q != C_K) begin
            t_d   = w_t2 >> LOGR;
            x_d   = x_q >> LOGR;
            cnt_d = cnt_q + 1'b1;
        end else begin
            // Product complete in w_res; set up the next multiplication
            t_d   = '0;
            cnt_d = '0;
            case (st_q)
                MS_TOM: begin
                    am_d  = w_res;
                    x_d   = C_R1;          // Montgomery form of 1
                    y_d   = C_R1;
                    idx_d = C_TOP;
                    st_d  = MS_SQR;
                end
                MS_SQR: begin
                    if (exp_q[idx_q]) begin
                        x_d  = w_res;
                        y_d  = am_q;
                        st_d = MS_MUL;
                    end else if (idx_q == '0) begin
                        x_d  = w_res;
                        y_d  = C_ONE;
                        st_d = MS_FROM;
                    end else begin
                        idx_d = idx_q - 1'b1;
                        x_d   = w_res;
                        y_d   = w_res;
                    end
                end
                MS_MUL: begin
                    if (idx_q == '0) begin
                        x_d  = w_res;
                        y_d  = C_ONE;
                        st_d = MS_FROM;
                    end else begin
                        idx_d = idx_q - 1'b1;
                        x_d   = w_res;
                        y_d   = w_res;
                        st_d  = MS_SQR;
                    end
                end
                MS_FROM: begin
                    z_d    = w_res;
                    done_d = 1'b1;
                    st_d   = MS_IDLE;
                end
                default: begin
                    st_d = MS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= MS_IDLE;
            x_q    <= '0;
            y_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            am_q   <= '0;
            exp_q  <= '0;
            idx_q  <= '0;
            z_q    <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            x_q    <= x_d;
            y_q    <= y_d;
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            am_q   <= am_d;
            exp_q  <= exp_d;
            idx_q  <= idx_d;
            z_q    <= z_d;
            done_q <= done_d;
        end
    end

    assign z    = z_q;
    assign done = done_q;

endmodule : mod_exp
`default_nettype wire

// File: rtl/rsa_codec.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_codec
//  Description : RSA encrypt/decrypt engine around mod_exp. Run-time
//                loadable exponents e and d, per-operand mode select,
//                valid/ready input and output streams, and range checking
//                of operands against the modulus.
//  Ports       : clk, rst              - clock; async active-high reset
//                key_wr/key_sel/key_data - exponent load (IDLE only)
//                in_valid/in_ready/in_mode/in_data - operand stream
//                out_valid/out_ready/out_data/out_err - result stream
//                busy                  - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_codec
    import rsa_pkg::*;
#(
    parameter int N      = TEST_N,
    parameter int N_BIT  = 12,
    parameter int LOGR   = 3,
    parameter int P      = 1,
    parameter int RMODN  = 545,
    parameter int R2MODN = 2292,
    parameter int E_INIT = TEST_E,
    parameter int D_INIT = TEST_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr,
    input  logic             key_sel,
    input  logic [N_BIT-1:0] key_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [N_BIT-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam logic [N_BIT-1:0] C_N = N_BIT'(N);

    state_t           state_q,      state_d;
    logic [N_BIT-1:0] e_q,          e_d;
    logic [N_BIT-1:0] d_q,          d_d;
    logic [N_BIT-1:0] op_q,         op_d;
    logic [N_BIT-1:0] exp_q,        exp_d;
    logic [N_BIT-1:0] out_data_q,   out_data_d;
    logic             out_err_q,    out_err_d;
    logic             wait_first_q, wait_first_d;

    logic             me_start;
    logic [N_BIT-1:0] me_z;
    logic             me_done;

    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        d_d          = d_q;
        op_d         = op_q;
        exp_d        = exp_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        wait_first_d = wait_first_q;
        case (state_q)
            ST_IDLE: begin
                if (key_wr) begin
                    if (key_sel) d_d = key_data;
                    else         e_d = key_data;
                end
                if (in_valid) begin
                    op_d  = in_data;
                    // Reads the registers, so a same-cycle key write
                    // only affects later operands
                    exp_d = (in_mode == MODE_DEC) ? d_q : e_q;
                    if (in_data >= C_N) begin
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        state_d    = ST_OUT;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                wait_first_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                wait_first_d = 1'b0;
                // A done in the first WAIT cycle may belong to a previous run
                if (!wait_first_q && me_done) begin
                    out_data_d = me_z;
                    out_err_d  = 1'b0;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            e_q          <= N_BIT'(E_INIT);
            d_q          <= N_BIT'(D_INIT);
            op_q         <= '0;
            exp_q        <= '0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            d_q          <= d_d;
            op_q         <= op_d;
            exp_q        <= exp_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign me_start  = (state_q == ST_START);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // op_q/exp_q only change in IDLE, so a and e are stable for the run
    mod_exp #(
        .N      (N),
        .N_BIT  (N_BIT),
        .LOGR   (LOGR),
        .P      (P),
        .RMODN  (RMODN),
        .R2MODN (R2MODN)
    ) u_mod_exp (
        .clk   (clk),
        .rst_n (~rst),
        .start (me_start),
        .a     (op_q),
        .e     (exp_q),
        .z     (me_z),
        .done  (me_done)
    );

endmodule : rsa_codec
`default_nettype wire

// File: tb/tb_rsa_codec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_codec
//  Description : Self-checking bench for rsa_codec against a plain
//                square-and-multiply reference of m^e mod N.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_codec;

    localparam int N_BIT = 12;
    localparam int MODN  = 3551;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_wr = 1'b0;
    logic             key_sel = 1'b0;
    logic [N_BIT-1:0] key_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_mode = 1'b0;
    logic [N_BIT-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N_BIT-1:0] out_data;
    logic             out_err;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int model_e = 5;
    int model_d = 1373;

    rsa_codec dut (
        .clk       (clk),
        .rst       (rst),
        .key_wr    (key_wr),
        .key_sel   (key_sel),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.me_start) start_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int unsigned ref_pow(input int unsigned b, input int unsigned x);
        int unsigned r = 1;
        int unsigned s = b % MODN;
        int unsigned k = x;
        while (k != 0) begin
            if (k % 2 == 1) r = (r * s) % MODN;
            s = (s * s) % MODN;
            k = k / 2;
        end
        return r % MODN;
    endfunction

    function automatic int unsigned expect_of(input int unsigned m, input logic mode);
        if (m >= MODN) return 0;
        return ref_pow(m, mode ? model_d : model_e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N_BIT-1:0] data, input logic mode,
                        input logic kw, input logic ksel, input logic [N_BIT-1:0] kdata);
        int n = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        key_wr   = kw;
        key_sel  = ksel;
        key_data = kdata;
        while (!in_ready && n < 1000) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        key_wr   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, {31'b0, out_valid}, 1);
    endtask

    task automatic recv(input string tag, input int unsigned want, input logic want_err);
        out_ready = 1'b1;
        wait_valid(tag);
        check({tag, "_data"}, {20'b0, out_data}, want);
        check({tag, "_err"}, {31'b0, out_err}, {31'b0, want_err});
        tick();
        out_ready = 1'b0;
    endtask

    task automatic key_write(input logic ksel, input logic [N_BIT-1:0] kdata);
        key_wr = 1'b1;
        key_sel = ksel;
        key_data = kdata;
        tick();
        key_wr = 1'b0;
    endtask

    initial begin
        int s0;
        int unsigned v;
        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", {20'b0, out_data}, 0);
        check("rst_out_err", {31'b0, out_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);

        // ---------------- basic encrypt / decrypt ----------------
        send(12'd2, 1'b0, 1'b0, 1'b0, '0);
        recv("enc2", 32, 1'b0);
        send(12'd32, 1'b1, 1'b0, 1'b0, '0);
        recv("dec32", 2, 1'b0);

        // ---------------- encrypt 1000 with held output ----------------
        v = expect_of(1000, 1'b0);
        check("ref_enc1000", v, 895);
        send(12'd1000, 1'b0, 1'b0, 1'b0, '0);
        wait_valid("hold");
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_data", {20'b0, out_data}, v);
            check("hold_busy", {31'b0, busy}, 1);
            check("hold_in_ready", {31'b0, in_ready}, 0);
            tick();
        end
        recv("enc1000", v, 1'b0);
        send(12'd895, 1'b1, 1'b0, 1'b0, '0);
        recv("dec895", 1000, 1'b0);

        // ---------------- range errors ----------------
        s0 = start_cnt;
        send(12'd3551, 1'b0, 1'b0, 1'b0, '0);
        check("err3551_lat", {31'b0, out_valid}, 1);
        recv("err3551", 0, 1'b1);
        send(12'd4095, 1'b1, 1'b0, 1'b0, '0);
        check("err4095_lat", {31'b0, out_valid}, 1);
        recv("err4095", 0, 1'b1);
        check("err_no_start", start_cnt, s0);
        send(12'd3550, 1'b0, 1'b0, 1'b0, '0);
        recv("enc3550", expect_of(3550, 1'b0), 1'b0);
        send(12'd0, 1'b0, 1'b0, 1'b0, '0);
        recv("enc0", 0, 1'b0);
        send(12'd1, 1'b1, 1'b0, 1'b0, '0);
        recv("dec1", 1, 1'b0);

        // ---------------- key writes ----------------
        key_write(1'b0, 12'd1);
        model_e = 1;
        send(12'd1234, 1'b0, 1'b0, 1'b0, '0);
        recv("enc1234_e1", 1234, 1'b0);
        // d write coincides with operand handshake: operand uses old d
        v = expect_of(1234, 1'b1);
        send(12'd1234, 1'b1, 1'b1, 1'b1, 12'd1);
        recv("dec_old_d", v, 1'b0);
        model_d = 1;
        send(12'd77, 1'b1, 1'b0, 1'b0, '0);
        recv("dec77_d1", 77, 1'b0);
        // key write during WAIT is dropped
        send(12'd500, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("wait_busy", {31'b0, busy}, 1);
        key_write(1'b0, 12'd7);
        recv("enc500_inflight", 500, 1'b0);
        send(12'd3, 1'b0, 1'b0, 1'b0, '0);
        recv("enc3_e_kept", 3, 1'b0);
        key_write(1'b0, 12'd0);
        model_e = 0;
        send(12'd999, 1'b0, 1'b0, 1'b0, '0);
        recv("enc999_e0", 1, 1'b0);

        // ---------------- asynchronous reset during WAIT ----------------
        send(12'd2, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_in_ready", {31'b0, in_ready}, 1);
        check("arst_out_valid", {31'b0, out_valid}, 0);
        check("arst_out_data", {20'b0, out_data}, 0);
        check("arst_out_err", {31'b0, out_err}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        tick();
        rst = 1'b0;
        model_e = 5;
        model_d = 1373;
        tick();
        check("arst_no_stale", {31'b0, out_valid}, 0);
        send(12'd2, 1'b0, 1'b0, 1'b0, '0);
        recv("post_rst_enc2", 32, 1'b0);

        // ---------------- random stream with output stalls ----------------
        begin
            int unsigned exp_q[$];
            int got = 0;
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        logic [N_BIT-1:0] m;
                        logic md;
                        m  = N_BIT'($urandom_range(0, MODN - 1));
                        md = 1'($urandom_range(0, 1));
                        in_valid = 1'b1;
                        in_data  = m;
                        in_mode  = md;
                        for (int n = 0; n < 2000 && !in_ready; n++) tick();
                        exp_q.push_back(expect_of(m, md));
                        tick();
                        in_valid = 1'b0;
                        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
                    end
                end
                begin
                    for (int n = 0; n < 6000 && got < 8; n++) begin
                        out_ready = 1'($urandom_range(0, 1));
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) begin
                                check("stream_extra", {31'b0, out_valid}, 0);
                            end else begin
                                check("stream_data", {20'b0, out_data}, exp_q.pop_front());
                                check("stream_err", {31'b0, out_err}, 0);
                            end
                            got++;
                        end
                        tick();
                    end
                    out_ready = 1'b0;
                end
            join
            check("stream_count", got, 8);
            check("stream_left", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rsa_codec
`default_nettype wire
